fnd_scan_controller: RTL and testbench

- Downstream consumer of the FND clock divider output. Time-multiplexes a 4-digit common-anode 7-segment display, one digit per rising edge of the divided clock.
- Converts a binary value to BCD with an iterative double-dabble engine, decodes each digit to active-low segment fonts, and drives active-low digit commons.
- Inserts a short all-off blanking gap at every digit switch to suppress ghosting.

---
 rtl/fnd_pkg.sv | 45 ++++
 rtl/fnd_bin2bcd.sv | 78 +++++++
 rtl/fnd_scan_controller.sv | 118 +++++++++++
 tb/tb_fnd_scan_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, segment fonts and converter state type for the FND scan controller.
package fnd_pkg;

    localparam int FND_NUM_DIGITS = 4;
    localparam int FND_BCD_W      = 4;
    localparam int FND_MAX_VALUE  = 9999;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp off.
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    function automatic logic [7:0] font_of(input logic [FND_BCD_W-1:0] nibble);
        logic [7:0] font;
        case (nibble)
            4'd0:    font = FONT_0;
            4'd1:    font = FONT_1;
            4'd2:    font = FONT_2;
            4'd3:    font = FONT_3;
            4'd4:    font = FONT_4;
            4'd5:    font = FONT_5;
            4'd6:    font = FONT_6;
            4'd7:    font = FONT_7;
            4'd8:    font = FONT_8;
            4'd9:    font = FONT_9;
            default: font = FONT_BLANK;
        endcase
        return font;
    endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per cycle,
// busy from the cycle after start until the done cycle inclusive.
module fnd_bin2bcd
    import fnd_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int BCD_DIGITS = FND_NUM_DIGITS
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_start,
    input  logic [VALUE_W-1:0]              i_bin,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [BCD_DIGITS*FND_BCD_W-1:0] o_bcd
);
    localparam int BCD_TOT = BCD_DIGITS * FND_BCD_W;
    localparam int CNT_W   = $clog2(VALUE_W + 1);

    conv_state_t        state_reg, state_next;
    logic [VALUE_W-1:0] bin_reg, bin_next;
    logic [BCD_TOT-1:0] bcd_reg, bcd_next;
    logic [BCD_TOT-1:0] bcd_adj;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    // Add-3 correction on every nibble that would overflow past 9 once doubled.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*FND_BCD_W +: FND_BCD_W] =
            (bcd_reg[gi*FND_BCD_W +: FND_BCD_W] >= FND_BCD_W'(5)) ?
            bcd_reg[gi*FND_BCD_W +: FND_BCD_W] + FND_BCD_W'(3) :
            bcd_reg[gi*FND_BCD_W +: FND_BCD_W];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            bcd_reg   <= bcd_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        bcd_next   = bcd_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    bin_next   = i_bin;
                    bcd_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(VALUE_W - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_busy = (state_reg != IDLE);
    assign o_done = (state_reg == DONE);
    assign o_bcd  = bcd_reg;

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with ghost-suppression blanking.
// Optional FND_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS   = FND_NUM_DIGITS,
    parameter int VALUE_W      = 14,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clk_fnd,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic [NUM_DIGITS-1:0] i_dp,
    output logic [NUM_DIGITS-1:0] o_fnd_com,
    output logic [7:0]            o_fnd_font,
    output logic                  o_overflow,
    output logic                  o_busy
);
    localparam int                 IDX_W     = $clog2(NUM_DIGITS);
    localparam int                 BLK_W     = $clog2(BLANK_CYCLES + 1);
    localparam int                 BCD_TOT   = NUM_DIGITS * FND_BCD_W;
    localparam logic [VALUE_W-1:0] MAX_VALUE = VALUE_W'(FND_MAX_VALUE);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic                  clk_fnd_d_reg;
    logic                  first_reg;
    logic                  scan_active_reg;
    logic                  ovf_pending_reg;
    logic                  overflow_reg;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [BLK_W-1:0]      blank_cnt_reg;
    logic [BCD_TOT-1:0]    bcd_disp_reg;
    logic [BCD_TOT-1:0]    conv_bcd;
    logic                  conv_busy, conv_done;
    logic                  scan_event, wrap_event, capture, value_over;
    logic [VALUE_W-1:0]    value_sat;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [FND_BCD_W-1:0]  digit_nib;
    logic [7:0]            digit_font;

    assign scan_event = i_clk_fnd & ~clk_fnd_d_reg;
    assign wrap_event = scan_event & (idx_reg == LAST_IDX);
    // A request arriving while a conversion runs is dropped on purpose.
    assign capture    = (wrap_event | first_reg) & ~conv_busy;
    assign value_over = (i_value > MAX_VALUE);
    assign value_sat  = value_over ? MAX_VALUE : i_value;
    assign idx_next   = wrap_event ? '0 : idx_reg + IDX_W'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            clk_fnd_d_reg   <= 1'b0;
            first_reg       <= 1'b1;
            scan_active_reg <= 1'b0;
            ovf_pending_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            idx_reg         <= '0;
            blank_cnt_reg   <= '0;
            bcd_disp_reg    <= '0;
        end else begin
            clk_fnd_d_reg <= i_clk_fnd;
            first_reg     <= 1'b0;
            if (scan_event) begin
                idx_reg         <= idx_next;
                blank_cnt_reg   <= BLK_W'(BLANK_CYCLES);
                scan_active_reg <= 1'b1;
            end else if (blank_cnt_reg != '0) begin
                blank_cnt_reg <= blank_cnt_reg - BLK_W'(1);
            end
            if (capture) begin
                ovf_pending_reg <= value_over;
            end
            // Digits and overflow flag change together so a frame is never torn.
            if (conv_done) begin
                bcd_disp_reg <= conv_bcd;
                overflow_reg <= ovf_pending_reg;
            end
        end
    end

    fnd_bin2bcd #(
        .VALUE_W   (VALUE_W),
        .BCD_DIGITS(NUM_DIGITS)
    ) u_bin2bcd (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_start  (capture),
        .i_bin    (value_sat),
        .o_busy   (conv_busy),
        .o_done   (conv_done),
        .o_bcd    (conv_bcd)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_com
        assign digit_sel[gi] = (idx_reg == IDX_W'(gi));
        assign o_fnd_com[gi] = ~(scan_active_reg & (blank_cnt_reg == '0) & digit_sel[gi]);
    end

    assign digit_nib = bcd_disp_reg[idx_reg*FND_BCD_W +: FND_BCD_W];

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] upper_zero;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign upper_zero[gi] = ~|bcd_disp_reg[BCD_TOT-1:gi*FND_BCD_W];
    end

    // Digit 0 always shows so that a value of zero renders as "0".
    assign digit_font = ((idx_reg != '0) && upper_zero[idx_reg]) ? FONT_BLANK : font_of(digit_nib);
`else
    assign digit_font = font_of(digit_nib);
`endif

    assign o_fnd_font = scan_active_reg ? (digit_font & ~{i_dp[idx_reg], 7'b0}) : FONT_BLANK;
    assign o_overflow = overflow_reg;
    assign o_busy     = conv_busy;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed, table-driven bench for fnd_scan_controller.
module tb_fnd_scan_controller;

    localparam int BLANK = 8;

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ    = 8'hFF;
    localparam logic [7:0] LZ_DP = 8'h7F;
`else
    localparam logic [7:0] LZ    = 8'hC0;
    localparam logic [7:0] LZ_DP = 8'h40;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_clk_fnd;
    logic [13:0] i_value;
    logic [3:0]  i_dp;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_font;
    logic        o_overflow;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    fnd_scan_controller dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_clk_fnd (i_clk_fnd),
        .i_value   (i_value),
        .i_dp      (i_dp),
        .o_fnd_com (o_fnd_com),
        .o_fnd_font(o_fnd_font),
        .o_overflow(o_overflow),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0]     value;
        logic [3:0]      dp;
        logic [3:0][7:0] font;
        logic            ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan edge, then sample the first cycle the new digit's common is on.
    task automatic scan(output logic [3:0] com, output logic [7:0] font);
        i_clk_fnd = 1'b1;
        tick();
        i_clk_fnd = 1'b0;
        repeat (BLANK) tick();
        @(negedge clk);
        com  = o_fnd_com;
        font = o_fnd_font;
        tick();
    endtask

    task automatic scan_check(input string name, input logic [3:0] exp_com, input logic [7:0] exp_font);
        logic [3:0] com;
        logic [7:0] font;
        scan(com, font);
        check({name, "_com"}, com, exp_com);
        check({name, "_font"}, font, exp_font);
    endtask

    // Never more than one digit common active at a time.
    always @(negedge clk) begin
        checks++;
        if ($countones(~o_fnd_com) > 1) begin
            errors++;
            $display("FAIL com_overlap actual=%b required at most one low", o_fnd_com);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] com;
        logic [7:0] font;
        logic [3:0] exp_com;

        vecs[0] = '{14'd12000, 4'b0000, {8'h90, 8'h90, 8'h90, 8'h90}, 1'b1};
        vecs[1] = '{14'd42,    4'b0000, {LZ,    LZ,    8'h99, 8'hA4}, 1'b0};
        vecs[2] = '{14'd5678,  4'b0100, {8'h92, 8'h02, 8'hF8, 8'h80}, 1'b0};
        vecs[3] = '{14'd7,     4'b0000, {LZ,    LZ,    LZ,    8'hF8}, 1'b0};
        vecs[4] = '{14'd0,     4'b0000, {LZ,    LZ,    LZ,    8'hC0}, 1'b0};
        vecs[5] = '{14'd9999,  4'b0000, {8'h90, 8'h90, 8'h90, 8'h90}, 1'b0};
        vecs[6] = '{14'd10000, 4'b0000, {8'h90, 8'h90, 8'h90, 8'h90}, 1'b1};
        vecs[7] = '{14'd16383, 4'b0000, {8'h90, 8'h90, 8'h90, 8'h90}, 1'b1};
        vecs[8] = '{14'd1000,  4'b1111, {8'h79, 8'h40, 8'h40, 8'h40}, 1'b0};
        vecs[9] = '{14'd7,     4'b1000, {LZ_DP, LZ,    LZ,    8'hF8}, 1'b0};

        rst_n     = 1'b1;
        i_clk_fnd = 1'b0;
        i_value   = 14'd0;
        i_dp      = 4'b0000;
        #1 rst_n  = 1'b0;

        // Reset held with the scan clock toggling.
        for (int k = 0; k < 6; k++) begin
            tick();
            i_clk_fnd = ~i_clk_fnd;
            @(negedge clk);
            check("rst_com", o_fnd_com, 4'hF);
            check("rst_font", o_fnd_font, 8'hFF);
            check("rst_busy", o_busy, 1'b0);
            check("rst_ovf", o_overflow, 1'b0);
        end
        $display("reset hold: com=%b font=%h", o_fnd_com, o_fnd_font);

        i_clk_fnd = 1'b0;
        i_value   = 14'd1234;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_release", o_busy, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            @(negedge clk);
            check("busy_run", o_busy, 1'b1);
        end
        tick();
        @(negedge clk);
        check("busy_end", o_busy, 1'b0);
        check("font_noscan", o_fnd_font, 8'hFF);
        tick();

        scan_check("v1234_d1", 4'b1101, 8'hB0);
        scan_check("v1234_d2", 4'b1011, 8'hA4);
        scan_check("v1234_d3", 4'b0111, 8'hF9);
        scan_check("v1234_d0", 4'b1110, 8'h99);
        $display("value 1234 scanned");

        for (int v = 0; v < 10; v++) begin
            i_value = vecs[v].value;
            i_dp    = vecs[v].dp;
            for (int s = 0; s < 4; s++) scan(com, font);
            repeat (10) tick();
            check("vec_ovf", o_overflow, vecs[v].ovf);
            for (int d = 1; d <= 4; d++) begin
                exp_com = ~(4'b0001 << (d % 4));
                scan(com, font);
                check("vec_com", com, exp_com);
                check("vec_font", font, vecs[v].font[d % 4]);
            end
            $display("vec %0d value=%0d dp=%b fonts=%h ovf=%b", v, vecs[v].value, vecs[v].dp,
                     vecs[v].font, o_overflow);
        end
        i_dp = 4'b0000;

        // Value change mid-frame is invisible until wrap + 16 cycles; blanking window timing.
        i_value = 14'd1111;
        for (int s = 0; s < 4; s++) scan(com, font);
        repeat (10) tick();
        scan_check("mid_d1", 4'b1101, 8'hF9);
        i_value = 14'd2222;
        scan_check("mid_d2", 4'b1011, 8'hF9);
        scan_check("mid_d3", 4'b0111, 8'hF9);
        i_clk_fnd = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            i_clk_fnd = 1'b0;
            @(negedge clk);
            if (k <= BLANK) check("blank_com", o_fnd_com, 4'hF);
            else            check("digit0_com", o_fnd_com, 4'hE);
            if (k == 15) check("old_font_n15", o_fnd_font, 8'hF9);
            if (k == 16) check("new_font_n16", o_fnd_font, 8'hA4);
        end
        tick();
        $display("mid-frame change 1111->2222 done");

        // A second scan edge during blanking restarts it for the newer digit.
        i_clk_fnd = 1'b1;
        tick();
        i_clk_fnd = 1'b0;
        tick();
        tick();
        i_clk_fnd = 1'b1;
        tick();
        i_clk_fnd = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        check("restart_blank_com", o_fnd_com, 4'hF);
        tick();
        @(negedge clk);
        check("restart_on_com", o_fnd_com, 4'b1011);
        check("restart_on_font", o_fnd_font, 8'hA4);
        tick();
        scan(com, font);
        scan(com, font);
        repeat (10) tick();
        $display("blank restart done");

        // A wrap arriving while the converter is busy is dropped.
        i_value = 14'd3456;
        for (int i = 0; i < 4; i++) begin
            i_clk_fnd = 1'b1;
            tick();
            i_clk_fnd = 1'b0;
            tick();
        end
        i_value = 14'd6543;
        for (int i = 0; i < 4; i++) begin
            i_clk_fnd = 1'b1;
            if (i == 3) begin
                @(negedge clk);
                check("busy_at_drop", o_busy, 1'b1);
            end
            tick();
            i_clk_fnd = 1'b0;
            tick();
        end
        repeat (20) tick();
        scan_check("drop_d1", 4'b1101, 8'h92);
        scan_check("drop_d2", 4'b1011, 8'h99);
        scan_check("drop_d3", 4'b0111, 8'hB0);
        scan_check("drop_d0", 4'b1110, 8'h82);
        repeat (10) tick();
        $display("dropped capture done");

        // Reset asserted mid-conversion clears outputs immediately.
        i_value = 14'd12000;
        for (int s = 0; s < 4; s++) scan(com, font);
        repeat (10) tick();
        for (int s = 0; s < 3; s++) scan(com, font);
        i_clk_fnd = 1'b1;
        tick();
        i_clk_fnd = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("pre_rst_busy", o_busy, 1'b1);
        check("pre_rst_ovf", o_overflow, 1'b1);
        check("pre_rst_font", o_fnd_font, 8'h90);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_com", o_fnd_com, 4'hF);
        check("mid_rst_font", o_fnd_font, 8'hFF);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_ovf", o_overflow, 1'b0);
        $display("reset mid-shift done");
        tick();
        rst_n = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
